// File: rtl/commit_trace_serializer.sv
// commit_trace_serializer
//   Transmit side of the commit-trace interface. Up to RETIRE_W retired uops
//   per cycle are compacted in program order into a circular FIFO and handed
//   out one record per cycle on a valid/ready port. commit_ready throttles
//   the ROB; a bundle offered while not ready is dropped and flagged in the
//   sticky overflow output.
//   Optional feature macro: COMMIT_TRACE_CSR_EN (adds a CSR-write side record
//   attached to the oldest valid slot of each pushed bundle).
module commit_trace_serializer #(
   parameter int RETIRE_W = 8,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 40,
   parameter int XLEN     = 64
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [RETIRE_W-1:0]        commit_valid,
   input  logic [RETIRE_W*ADDR_W-1:0] commit_pc,
   input  logic [RETIRE_W*32-1:0]     commit_inst,
   input  logic [RETIRE_W*XLEN-1:0]   commit_wdata,
   input  logic [RETIRE_W*5-1:0]      commit_ldst,
   input  logic [RETIRE_W*3-1:0]      commit_rtype,
`ifdef COMMIT_TRACE_CSR_EN
   input  logic [2:0]                 csrwr_cmd,
   input  logic [11:0]                csrwr_addr,
   input  logic [XLEN-1:0]            csrwr_wdata,
   output logic                       trace_csr_valid,
   output logic [11:0]                trace_csr_addr,
   output logic [XLEN-1:0]            trace_csr_wdata,
`endif
   output logic                       commit_ready,
   output logic                       trace_valid,
   input  logic                       trace_ready,
   output logic [ADDR_W-1:0]          trace_pc,
   output logic [31:0]                trace_inst,
   output logic [XLEN-1:0]            trace_wdata,
   output logic [4:0]                 trace_ldst,
   output logic [2:0]                 trace_rtype,
   output logic [63:0]                trace_seq,
   output logic                       overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   // Highest occupancy that still leaves room for a full bundle.
   localparam logic [CNT_W-1:0] READY_LIMIT = CNT_W'(DEPTH - RETIRE_W);

   // FIFO storage, one array per record field.
   logic [ADDR_W-1:0] pc_mem_r    [DEPTH];
   logic [31:0]       inst_mem_r  [DEPTH];
   logic [XLEN-1:0]   wdata_mem_r [DEPTH];
   logic [4:0]        ldst_mem_r  [DEPTH];
   logic [2:0]        rtype_mem_r [DEPTH];
`ifdef COMMIT_TRACE_CSR_EN
   logic              csr_v_mem_r [DEPTH];
   logic [11:0]       csr_a_mem_r [DEPTH];
   logic [XLEN-1:0]   csr_d_mem_r [DEPTH];
   logic [RETIRE_W-1:0] first_s;
`endif

   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_next_s;
   logic [CNT_W-1:0] push_cnt_s;
   logic [PTR_W-1:0] widx_s [RETIRE_W];
   logic             commit_ready_r;
   logic             trace_valid_r;
   logic             overflow_r;
   logic [63:0]      seq_r;
   logic             any_valid_s;
   logic             push_s;
   logic             drop_s;
   logic             pop_s;

   // Compaction: each valid slot is placed right after all older valid slots.
   always_comb begin
      push_cnt_s = '0;
      widx_s     = '{default: '0};
`ifdef COMMIT_TRACE_CSR_EN
      first_s    = '0;
`endif
      for (int i = 0; i < RETIRE_W; i++) begin
         widx_s[i] = wr_ptr_r + push_cnt_s[PTR_W-1:0];
`ifdef COMMIT_TRACE_CSR_EN
         first_s[i] = (push_cnt_s == '0);
`endif
         if (commit_valid[i]) begin
            push_cnt_s = push_cnt_s + CNT_W'(1);
         end else begin
            push_cnt_s = push_cnt_s;
         end
      end
   end

   // Push / drop / pop decisions and the next FIFO occupancy.
   always_comb begin
      any_valid_s  = |commit_valid;
      push_s       = any_valid_s & commit_ready_r;
      drop_s       = any_valid_s & ~commit_ready_r;
      pop_s        = trace_valid_r & trace_ready;
      count_next_s = count_r;
      if (push_s) begin
         count_next_s = count_next_s + push_cnt_s;
      end else begin
         count_next_s = count_next_s;
      end
      if (pop_s) begin
         count_next_s = count_next_s - CNT_W'(1);
      end else begin
         count_next_s = count_next_s;
      end
   end

   // Pointers, occupancy, registered status flags and the record sequence counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr_r       <= '0;
         wr_ptr_r       <= '0;
         count_r        <= '0;
         commit_ready_r <= 1'b1;
         trace_valid_r  <= 1'b0;
         overflow_r     <= 1'b0;
         seq_r          <= 64'd0;
      end else begin
         count_r        <= count_next_s;
         commit_ready_r <= (count_next_s <= READY_LIMIT);
         trace_valid_r  <= (count_next_s != '0);
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + push_cnt_s[PTR_W-1:0];
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            seq_r    <= seq_r + 64'd1;
         end
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // FIFO storage: every valid slot of an accepted bundle writes its compacted entry.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int e = 0; e < DEPTH; e++) begin
            pc_mem_r[e]    <= '0;
            inst_mem_r[e]  <= '0;
            wdata_mem_r[e] <= '0;
            ldst_mem_r[e]  <= '0;
            rtype_mem_r[e] <= '0;
`ifdef COMMIT_TRACE_CSR_EN
            csr_v_mem_r[e] <= 1'b0;
            csr_a_mem_r[e] <= '0;
            csr_d_mem_r[e] <= '0;
`endif
         end
      end else begin
         for (int i = 0; i < RETIRE_W; i++) begin
            if (push_s && commit_valid[i]) begin
               pc_mem_r[widx_s[i]]    <= commit_pc[i*ADDR_W +: ADDR_W];
               inst_mem_r[widx_s[i]]  <= commit_inst[i*32 +: 32];
               wdata_mem_r[widx_s[i]] <= commit_wdata[i*XLEN +: XLEN];
               ldst_mem_r[widx_s[i]]  <= commit_ldst[i*5 +: 5];
               rtype_mem_r[widx_s[i]] <= commit_rtype[i*3 +: 3];
`ifdef COMMIT_TRACE_CSR_EN
               // Only the oldest valid slot of the bundle carries the CSR write.
               csr_v_mem_r[widx_s[i]] <= first_s[i] & (csrwr_cmd != 3'd0);
               csr_a_mem_r[widx_s[i]] <= csrwr_addr;
               csr_d_mem_r[widx_s[i]] <= csrwr_wdata;
`endif
            end
         end
      end
   end

   assign commit_ready = commit_ready_r;
   assign trace_valid  = trace_valid_r;
   assign overflow     = overflow_r;
   assign trace_seq    = seq_r;
   assign trace_pc     = pc_mem_r[rd_ptr_r];
   assign trace_inst   = inst_mem_r[rd_ptr_r];
   assign trace_wdata  = wdata_mem_r[rd_ptr_r];
   assign trace_ldst   = ldst_mem_r[rd_ptr_r];
   assign trace_rtype  = rtype_mem_r[rd_ptr_r];
`ifdef COMMIT_TRACE_CSR_EN
   assign trace_csr_valid = trace_valid_r & csr_v_mem_r[rd_ptr_r];
   assign trace_csr_addr  = csr_a_mem_r[rd_ptr_r];
   assign trace_csr_wdata = csr_d_mem_r[rd_ptr_r];
`endif

endmodule

// File: tb/tb_commit_trace_serializer.sv
// Self-checking bench for commit_trace_serializer: directed table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_commit_trace_serializer;

   localparam int RW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 40;
   localparam int XL    = 64;

   logic             clock = 1'b0;
   logic             reset;
   logic [RW-1:0]    commit_valid;
   logic [RW*AW-1:0] commit_pc;
   logic [RW*32-1:0] commit_inst;
   logic [RW*XL-1:0] commit_wdata;
   logic [RW*5-1:0]  commit_ldst;
   logic [RW*3-1:0]  commit_rtype;
   logic             commit_ready;
   logic             trace_valid;
   logic             trace_ready;
   logic [AW-1:0]    trace_pc;
   logic [31:0]      trace_inst;
   logic [XL-1:0]    trace_wdata;
   logic [4:0]       trace_ldst;
   logic [2:0]       trace_rtype;
   logic [63:0]      trace_seq;
   logic             overflow;
`ifdef COMMIT_TRACE_CSR_EN
   logic [2:0]       csrwr_cmd;
   logic [11:0]      csrwr_addr;
   logic [XL-1:0]    csrwr_wdata;
   logic             trace_csr_valid;
   logic [11:0]      trace_csr_addr;
   logic [XL-1:0]    trace_csr_wdata;
`endif

   commit_trace_serializer dut (
      .clock        (clock),
      .reset        (reset),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .commit_inst  (commit_inst),
      .commit_wdata (commit_wdata),
      .commit_ldst  (commit_ldst),
      .commit_rtype (commit_rtype),
`ifdef COMMIT_TRACE_CSR_EN
      .csrwr_cmd       (csrwr_cmd),
      .csrwr_addr      (csrwr_addr),
      .csrwr_wdata     (csrwr_wdata),
      .trace_csr_valid (trace_csr_valid),
      .trace_csr_addr  (trace_csr_addr),
      .trace_csr_wdata (trace_csr_wdata),
`endif
      .commit_ready (commit_ready),
      .trace_valid  (trace_valid),
      .trace_ready  (trace_ready),
      .trace_pc     (trace_pc),
      .trace_inst   (trace_inst),
      .trace_wdata  (trace_wdata),
      .trace_ldst   (trace_ldst),
      .trace_rtype  (trace_rtype),
      .trace_seq    (trace_seq),
      .overflow     (overflow)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // Reference model: an in-order queue of records plus sequence and overflow state.
   typedef struct {
      logic [AW-1:0] pc;
      logic [31:0]   inst;
      logic [XL-1:0] wdata;
      logic [4:0]    ldst;
      logic [2:0]    rtype;
      logic          csr_v;
      logic [11:0]   csr_a;
      logic [XL-1:0] csr_d;
   } rec_t;

   rec_t        mq[$];
   logic [63:0] m_seq = 64'd0;
   logic        m_ovf = 1'b0;

   typedef struct {
      logic [7:0]  valid;
      logic        rdy;
      int          reps;
      logic        exp_tv;
      logic        exp_cr;
      logic        exp_ovf;
      logic [63:0] exp_seq;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_seq = 64'd0;
      m_ovf = 1'b0;
   endtask

   task automatic cmp_model();
      chk("trace_valid", {63'd0, trace_valid}, {63'd0, mq.size() != 0});
      chk("commit_ready", {63'd0, commit_ready}, {63'd0, (DEPTH - mq.size()) >= RW});
      chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
      chk("trace_seq", trace_seq, m_seq);
      if (mq.size() != 0) begin
         chk("trace_pc", {24'd0, trace_pc}, {24'd0, mq[0].pc});
         chk("trace_inst", {32'd0, trace_inst}, {32'd0, mq[0].inst});
         chk("trace_wdata", trace_wdata, mq[0].wdata);
         chk("trace_ldst", {59'd0, trace_ldst}, {59'd0, mq[0].ldst});
         chk("trace_rtype", {61'd0, trace_rtype}, {61'd0, mq[0].rtype});
`ifdef COMMIT_TRACE_CSR_EN
         chk("trace_csr_valid", {63'd0, trace_csr_valid}, {63'd0, mq[0].csr_v});
         if (mq[0].csr_v) begin
            chk("trace_csr_addr", {52'd0, trace_csr_addr}, {52'd0, mq[0].csr_a});
            chk("trace_csr_wdata", trace_csr_wdata, mq[0].csr_d);
         end
`endif
      end
   endtask

   // One clock: drive the bundle, step the model by the interface rules, compare.
   task automatic cycle(input logic [RW-1:0] v, input logic rdy);
      rec_t r;
      logic m_pop;
      logic m_rdy;
      logic first;
      commit_valid = v;
      trace_ready  = rdy;
      m_pop = (mq.size() != 0) && rdy;
      m_rdy = (DEPTH - mq.size()) >= RW;
      @(posedge clock);
      #1;
      if (m_pop) begin
         void'(mq.pop_front());
         m_seq = m_seq + 64'd1;
      end
      if (v != '0) begin
         if (m_rdy) begin
            first = 1'b1;
            for (int i = 0; i < RW; i++) begin
               if (v[i]) begin
                  r = '{default: '0};
                  r.pc    = commit_pc[i*AW +: AW];
                  r.inst  = commit_inst[i*32 +: 32];
                  r.wdata = commit_wdata[i*XL +: XL];
                  r.ldst  = commit_ldst[i*5 +: 5];
                  r.rtype = commit_rtype[i*3 +: 3];
`ifdef COMMIT_TRACE_CSR_EN
                  r.csr_v = first && (csrwr_cmd != 3'd0);
                  r.csr_a = csrwr_addr;
                  r.csr_d = csrwr_wdata;
`endif
                  first = 1'b0;
                  mq.push_back(r);
               end
            end
         end else begin
            m_ovf = 1'b1;
         end
      end
      cmp_model();
   endtask

   task automatic set_data(input logic [AW-1:0] base);
      for (int i = 0; i < RW; i++) begin
         commit_pc[i*AW +: AW]    = base + AW'(4 * i);
         commit_inst[i*32 +: 32]  = 32'h00000013 | (32'(i) << 7);
         commit_wdata[i*XL +: XL] = {24'd0, base} ^ 64'(i * 33);
         commit_ldst[i*5 +: 5]    = 5'(i + 1);
         commit_rtype[i*3 +: 3]   = 3'(i);
      end
   endtask

   task automatic rand_data();
      for (int i = 0; i < RW; i++) begin
         commit_pc[i*AW +: AW]    = {8'(($urandom)), $urandom};
         commit_inst[i*32 +: 32]  = $urandom;
         commit_wdata[i*XL +: XL] = {$urandom, $urandom};
         commit_ldst[i*5 +: 5]    = 5'($urandom);
         commit_rtype[i*3 +: 3]   = 3'($urandom);
      end
   endtask

   initial begin
      logic [RW-1:0] v;
      logic [AW-1:0] exp_pc;
      logic [63:0]   seq_base;

      reset        = 1'b0;
      commit_valid = '0;
      commit_pc    = '0;
      commit_inst  = '0;
      commit_wdata = '0;
      commit_ldst  = '0;
      commit_rtype = '0;
      trace_ready  = 1'b0;
`ifdef COMMIT_TRACE_CSR_EN
      csrwr_cmd    = 3'd0;
      csrwr_addr   = 12'd0;
      csrwr_wdata  = '0;
`endif

      // table: {valid, trace_ready, repeats, exp trace_valid, commit_ready, overflow, seq}
      tbl[0] = '{8'hFF, 1'b0, 1, 1'b1, 1'b1, 1'b0, 64'd0};  // count 8
      tbl[1] = '{8'hFF, 1'b0, 1, 1'b1, 1'b0, 1'b0, 64'd0};  // count 16, full
      tbl[2] = '{8'h01, 1'b0, 1, 1'b1, 1'b0, 1'b1, 64'd0};  // dropped -> overflow
      tbl[3] = '{8'h00, 1'b1, 1, 1'b1, 1'b0, 1'b1, 64'd1};  // count 15, not credited
      tbl[4] = '{8'h00, 1'b1, 7, 1'b1, 1'b1, 1'b1, 64'd8};  // count 8
      tbl[5] = '{8'hFF, 1'b1, 1, 1'b1, 1'b0, 1'b1, 64'd9};  // push 8 + pop -> 15

      // Reset state with all inputs low.
      repeat (2) @(posedge clock);
      #1;
      chk("rst.trace_valid", {63'd0, trace_valid}, 64'd0);
      chk("rst.commit_ready", {63'd0, commit_ready}, 64'd1);
      chk("rst.overflow", {63'd0, overflow}, 64'd0);
      chk("rst.trace_seq", trace_seq, 64'd0);
      reset = 1'b1;
      model_reset();

      // Single record from slot 0.
      commit_pc[AW-1:0]  = 40'h0080000000;
      commit_inst[31:0]  = 32'h00100093;
      cycle(8'h01, 1'b1);
      chk("single.pc", {24'd0, trace_pc}, 64'h80000000);
      chk("single.inst", {32'd0, trace_inst}, 64'h00100093);
      chk("single.seq", trace_seq, 64'd0);
      cycle(8'h00, 1'b1);
      chk("single.drained", {63'd0, trace_valid}, 64'd0);

      // Full bundle: eight records, pc ascending, consecutive sequence numbers.
      set_data(40'h1000);
      cycle(8'hFF, 1'b1);
      seq_base = 64'd1;
      for (int k = 0; k < 8; k++) begin
         exp_pc = 40'h1000 + 40'(4 * k);
         chk("full.pc", {24'd0, trace_pc}, {24'd0, exp_pc});
         chk("full.seq", trace_seq, seq_base + 64'(k));
         cycle(8'h00, 1'b1);
      end
      chk("full.drained", {63'd0, trace_valid}, 64'd0);

      // Sparse bundle 8'hA5 compacts to slots 0,2,5,7.
      set_data(40'h2000);
      cycle(8'hA5, 1'b1);
      chk("sparse.pc0", {24'd0, trace_pc}, 64'h2000);
      cycle(8'h00, 1'b1);
      chk("sparse.pc2", {24'd0, trace_pc}, 64'h2008);
      cycle(8'h00, 1'b1);
      chk("sparse.pc5", {24'd0, trace_pc}, 64'h2014);
      cycle(8'h00, 1'b1);
      chk("sparse.pc7", {24'd0, trace_pc}, 64'h201C);
      cycle(8'h00, 1'b1);
      chk("sparse.drained", {63'd0, trace_valid}, 64'd0);
      chk("sparse.seq", trace_seq, 64'd13);

      // Fill / overflow / drain-with-push table, starting from a fresh reset.
      reset = 1'b0;
      #1;
      reset = 1'b1;
      model_reset();
      for (int k = 0; k < 6; k++) begin
         for (int r = 0; r < tbl[k].reps; r++) begin
            set_data(40'h1000 * 40'(k + 1));
            cycle(tbl[k].valid, tbl[k].rdy);
         end
         chk($sformatf("tbl%0d.trace_valid", k), {63'd0, trace_valid}, {63'd0, tbl[k].exp_tv});
         chk($sformatf("tbl%0d.commit_ready", k), {63'd0, commit_ready}, {63'd0, tbl[k].exp_cr});
         chk($sformatf("tbl%0d.overflow", k), {63'd0, overflow}, {63'd0, tbl[k].exp_ovf});
         chk($sformatf("tbl%0d.trace_seq", k), trace_seq, tbl[k].exp_seq);
      end

      // Reset asserted mid-stream clears outputs without waiting for a clock edge.
      reset = 1'b0;
      #1;
      chk("midrst.trace_valid", {63'd0, trace_valid}, 64'd0);
      chk("midrst.commit_ready", {63'd0, commit_ready}, 64'd1);
      chk("midrst.overflow", {63'd0, overflow}, 64'd0);
      chk("midrst.trace_seq", trace_seq, 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      model_reset();

`ifdef COMMIT_TRACE_CSR_EN
      // CSR write rides on the lowest valid slot only.
      set_data(40'h3000);
      csrwr_cmd   = 3'd1;
      csrwr_addr  = 12'h300;
      csrwr_wdata = 64'hDEAD_BEEF;
      cycle(8'h06, 1'b0);
      csrwr_cmd   = 3'd0;
      chk("csr.slot1.valid", {63'd0, trace_csr_valid}, 64'd1);
      chk("csr.slot1.addr", {52'd0, trace_csr_addr}, 64'h300);
      cycle(8'h00, 1'b1);
      chk("csr.slot2.pc", {24'd0, trace_pc}, 64'h3008);
      chk("csr.slot2.valid", {63'd0, trace_csr_valid}, 64'd0);
      cycle(8'h00, 1'b1);
`endif

      // Randomized traffic: mostly sparse bundles, occasional dense ones.
      for (int n = 0; n < 400; n++) begin
         rand_data();
         if ($urandom_range(0, 7) == 0) begin
            v = 8'($urandom);
         end else begin
            v = 8'($urandom & $urandom & $urandom);
         end
`ifdef COMMIT_TRACE_CSR_EN
         csrwr_cmd   = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0;
         csrwr_addr  = 12'($urandom);
         csrwr_wdata = {$urandom, $urandom};
`endif
         cycle(v, $urandom_range(0, 4) != 0);
         if (n == 200) begin
            reset = 1'b0;
            #1;
            reset = 1'b1;
            model_reset();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
